hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It centralises four decisions in one block: load-use stalls, branch/jump flushes, forwarding selection, and a multi-cycle data-memory wait state machine. This resolves stall/flush conflicts with a fixed priority. It sits beside the pipeline registers in the `mips` top and drives their write-enable, flush and freeze inputs plus the EX-stage operand muxes.

---
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use / interlock
// stalls, redirect flushes, EX operand forwarding and the data-memory wait FSM.
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwr,
  input  logic              ex_memrd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwr,
  input  logic              mem_memrd,
  input  logic              mem_memwr,
  input  logic              mem_redirect,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwr,
  output logic              pc_wr,
  output logic              if2id_wr,
  output logic              if2id_flush,
  output logic              id2ex_flush,
  output logic              ex2mem_flush,
  output logic              frz,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam bit MULTI = (MEM_LAT > 1);
  localparam logic [CW-1:0] LOAD_VAL = MULTI ? CW'(MEM_LAT - 2) : '0;

  typedef enum logic {M_IDLE, M_WAIT} mstate_t;

  mstate_t          r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic              w_access;
  logic              w_frz;
  logic              w_lu;
  logic              w_il;
  logic              w_hz;
  logic [2:0]        w_il_hit;
  logic [REG_AW-1:0] w_prod_rd [3];
  logic [2:0]        w_prod_wr;
  logic [REG_AW-1:0] w_ex_src  [2];
  logic [1:0]        w_fwd     [2];

  assign w_access = mem_memrd | mem_memwr;
  assign w_frz = !rst && ((r_state == M_IDLE && w_access && MULTI) ||
                          (r_state == M_WAIT && r_cnt != '0));

  assign w_lu = ex_memrd && (ex_rd != '0) &&
                ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));

  // Pure-interlock mode: any in-flight producer of a used ID source stalls.
  assign w_prod_rd[0] = ex_rd;
  assign w_prod_rd[1] = mem_rd;
  assign w_prod_rd[2] = wb_rd;
  assign w_prod_wr    = {wb_regwr, mem_regwr, ex_regwr};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_il
      assign w_il_hit[gi] = w_prod_wr[gi] && (w_prod_rd[gi] != '0) &&
                            ((id_use_rs && w_prod_rd[gi] == id_rs) ||
                             (id_use_rt && w_prod_rd[gi] == id_rt));
    end
  endgenerate

  assign w_il = (FWD_EN == 0) && (|w_il_hit);
  assign w_hz = w_lu | w_il;

  assign w_ex_src[0] = ex_rs;
  assign w_ex_src[1] = ex_rt;

  // MEM result is younger than WB, so it wins when both match.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        w_fwd[gi] = 2'b00;
        if (FWD_EN != 0) begin
          if (mem_regwr && mem_rd != '0 && mem_rd == w_ex_src[gi])
            w_fwd[gi] = 2'b10;
          else if (wb_regwr && wb_rd != '0 && wb_rd == w_ex_src[gi])
            w_fwd[gi] = 2'b01;
        end
      end
    end
  endgenerate

  always_comb begin
    pc_wr        = 1'b1;
    if2id_wr     = 1'b1;
    if2id_flush  = 1'b0;
    id2ex_flush  = 1'b0;
    ex2mem_flush = 1'b0;
    fwd_a        = w_fwd[0];
    fwd_b        = w_fwd[1];
    if (rst) begin
      if2id_flush  = 1'b1;
      id2ex_flush  = 1'b1;
      ex2mem_flush = 1'b1;
      fwd_a        = 2'b00;
      fwd_b        = 2'b00;
    end else if (w_frz) begin
      pc_wr    = 1'b0;
      if2id_wr = 1'b0;
    end else if (mem_redirect) begin
      id2ex_flush  = 1'b1;
      ex2mem_flush = 1'b1;
    end else if (w_hz) begin
      pc_wr       = 1'b0;
      if2id_wr    = 1'b0;
      id2ex_flush = 1'b1;
    end
  end

  assign frz          = w_frz;
  assign stall_cycles = r_stall_cnt;
  assign flush_events = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= M_IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        M_IDLE: begin
          if (w_access && MULTI) begin
            r_cnt   <= LOAD_VAL;
            r_state <= M_WAIT;
          end
        end
        M_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else r_state <= M_IDLE;
        end
        default: r_state <= M_IDLE;
      endcase
      if ((w_frz || (w_hz && !mem_redirect)) && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (mem_redirect && !w_frz && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (default, MEM_LAT=4 with 2-bit
// counters, FWD_EN=0) share one set of pipeline-state stimulus.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, ex_regwr, ex_memrd;
  logic       mem_regwr, mem_memrd, mem_memwr, mem_redirect, wb_regwr;

  logic        d0_pc_wr, d0_if2id_wr, d0_if2id_flush, d0_id2ex_flush, d0_ex2mem_flush, d0_frz;
  logic [1:0]  d0_fwd_a, d0_fwd_b;
  logic [15:0] d0_stall, d0_flush;
  logic        l4_pc_wr, l4_if2id_wr, l4_if2id_flush, l4_id2ex_flush, l4_ex2mem_flush, l4_frz;
  logic [1:0]  l4_fwd_a, l4_fwd_b;
  logic [1:0]  l4_stall, l4_flush;
  logic        nf_pc_wr, nf_if2id_wr, nf_if2id_flush, nf_id2ex_flush, nf_ex2mem_flush, nf_frz;
  logic [1:0]  nf_fwd_a, nf_fwd_b;
  logic [15:0] nf_stall, nf_flush;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr), .mem_memrd(mem_memrd), .mem_memwr(mem_memwr),
    .mem_redirect(mem_redirect), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .pc_wr(d0_pc_wr), .if2id_wr(d0_if2id_wr), .if2id_flush(d0_if2id_flush),
    .id2ex_flush(d0_id2ex_flush), .ex2mem_flush(d0_ex2mem_flush), .frz(d0_frz),
    .fwd_a(d0_fwd_a), .fwd_b(d0_fwd_b), .stall_cycles(d0_stall), .flush_events(d0_flush)
  );

  hazard_ctrl #(.MEM_LAT(4), .CNT_W(2)) u_lat4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr), .mem_memrd(mem_memrd), .mem_memwr(mem_memwr),
    .mem_redirect(mem_redirect), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .pc_wr(l4_pc_wr), .if2id_wr(l4_if2id_wr), .if2id_flush(l4_if2id_flush),
    .id2ex_flush(l4_id2ex_flush), .ex2mem_flush(l4_ex2mem_flush), .frz(l4_frz),
    .fwd_a(l4_fwd_a), .fwd_b(l4_fwd_b), .stall_cycles(l4_stall), .flush_events(l4_flush)
  );

  hazard_ctrl #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr), .mem_memrd(mem_memrd), .mem_memwr(mem_memwr),
    .mem_redirect(mem_redirect), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .pc_wr(nf_pc_wr), .if2id_wr(nf_if2id_wr), .if2id_flush(nf_if2id_flush),
    .id2ex_flush(nf_id2ex_flush), .ex2mem_flush(nf_ex2mem_flush), .frz(nf_frz),
    .fwd_a(nf_fwd_a), .fwd_b(nf_fwd_b), .stall_cycles(nf_stall), .flush_events(nf_flush)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwr = 0; ex_memrd = 0;
    mem_rd = 0; mem_regwr = 0; mem_memrd = 0; mem_memwr = 0; mem_redirect = 0;
    wb_rd = 0; wb_regwr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    tick();
    rst = 1'b0;
  endtask

  // Producer of $7 sits 'start' stages ahead (1=EX, 2=MEM, 3=WB) of the consumer in ID.
  task automatic dep(input int start);
    for (int s = start; s <= 3; s++) begin
      ex_regwr = (s == 1);  ex_rd  = (s == 1) ? 5'd7 : 5'd0;
      mem_regwr = (s == 2); mem_rd = (s == 2) ? 5'd7 : 5'd0;
      wb_regwr = (s == 3);  wb_rd  = (s == 3) ? 5'd7 : 5'd0;
      settle();
      check_eq($sformatf("nf_d%0d_s%0d_pc_wr", start, s), nf_pc_wr, 0);
      check_eq($sformatf("nf_d%0d_s%0d_id2ex_flush", start, s), nf_id2ex_flush, 1);
      check_eq($sformatf("nf_d%0d_s%0d_fwd", start, s), {nf_fwd_a, nf_fwd_b}, 0);
      tick();
    end
    ex_regwr = 0; ex_rd = 0; mem_regwr = 0; mem_rd = 0; wb_regwr = 0; wb_rd = 0;
    settle();
    check_eq($sformatf("nf_d%0d_release_pc_wr", start), nf_pc_wr, 1);
    tick();
  endtask

  initial begin
    // Reset forcing, with a would-be MEM forward present
    rst = 1'b1;
    clear_in();
    mem_regwr = 1; mem_rd = 1; ex_rs = 1; ex_rt = 1;
    tick();
    settle();
    check_eq("rst_pc_wr", d0_pc_wr, 1);
    check_eq("rst_if2id_wr", d0_if2id_wr, 1);
    check_eq("rst_frz", d0_frz, 0);
    check_eq("rst_flushes", {d0_if2id_flush, d0_id2ex_flush, d0_ex2mem_flush}, 3'b111);
    check_eq("rst_fwd", {d0_fwd_a, d0_fwd_b}, 0);
    tick();
    rst = 1'b0;
    clear_in();
    settle();
    check_eq("post_rst_counters", {d0_stall, d0_flush}, 0);
    check_eq("post_rst_flushes", {d0_if2id_flush, d0_id2ex_flush, d0_ex2mem_flush}, 0);

    // lw $1 in EX, add $2,$1,$1 in ID
    do_reset();
    ex_memrd = 1; ex_regwr = 1; ex_rd = 1;
    id_rs = 1; id_rt = 1; id_use_rs = 1; id_use_rt = 1;
    settle();
    check_eq("lu_pc_wr", d0_pc_wr, 0);
    check_eq("lu_if2id_wr", d0_if2id_wr, 0);
    check_eq("lu_flushes", {d0_if2id_flush, d0_id2ex_flush, d0_ex2mem_flush}, 3'b010);
    tick();
    clear_in();
    id_rs = 1; id_rt = 1; id_use_rs = 1; id_use_rt = 1;
    mem_memrd = 1; mem_regwr = 1; mem_rd = 1;
    settle();
    check_eq("lu_bubble_pc_wr", d0_pc_wr, 1);
    tick();
    clear_in();
    wb_regwr = 1; wb_rd = 1;
    ex_rs = 1; ex_rt = 1; ex_rd = 2; ex_regwr = 1;
    settle();
    check_eq("lu_consumer_fwd", {d0_fwd_a, d0_fwd_b}, 4'b0101);
    check_eq("lu_stall_cycles", d0_stall, 1);
    tick();

    // add $3 in MEM, sub $4,$3,$3 in EX; WB also holds an older $3
    clear_in();
    mem_regwr = 1; mem_rd = 3; wb_regwr = 1; wb_rd = 3; ex_rs = 3; ex_rt = 3;
    settle();
    check_eq("fwd_mem_beats_wb", {d0_fwd_a, d0_fwd_b}, 4'b1010);
    check_eq("fwd_no_stall", d0_pc_wr, 1);
    ex_rt = 5; wb_rd = 5;
    settle();
    check_eq("fwd_split", {d0_fwd_a, d0_fwd_b}, 4'b1001);
    mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
    settle();
    check_eq("fwd_r0_none", {d0_fwd_a, d0_fwd_b}, 0);
    tick();

    // Load-use coincident with redirect
    do_reset();
    ex_memrd = 1; ex_regwr = 1; ex_rd = 1;
    id_rs = 1; id_use_rs = 1; mem_redirect = 1;
    settle();
    check_eq("redir_pc_if_wr", {d0_pc_wr, d0_if2id_wr}, 2'b11);
    check_eq("redir_flushes", {d0_if2id_flush, d0_id2ex_flush, d0_ex2mem_flush}, 3'b011);
    tick();
    clear_in();
    settle();
    check_eq("redir_stall_cycles", d0_stall, 0);
    check_eq("redir_flush_events", d0_flush, 1);

    // MEM_LAT=4: sw in MEM with redirect pending during the freeze
    do_reset();
    mem_memwr = 1; mem_redirect = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check_eq($sformatf("lat4_c%0d_frz", c), l4_frz, (c < 3));
      check_eq($sformatf("lat4_c%0d_pc_wr", c), l4_pc_wr, (c == 3));
      check_eq($sformatf("lat4_c%0d_flushes", c),
               {l4_if2id_flush, l4_id2ex_flush, l4_ex2mem_flush}, (c == 3) ? 3'b011 : 3'b000);
      tick();
    end
    mem_redirect = 0;
    settle();
    check_eq("lat4_retrigger_frz", l4_frz, 1);
    check_eq("lat4_stall_cycles", l4_stall, 3);
    check_eq("lat4_flush_events", l4_flush, 1);
    tick();
    settle();
    check_eq("lat4_stall_saturated", l4_stall, 3);
    check_eq("lat4_2nd_frozen", l4_frz, 1);
    rst = 1;
    settle();
    check_eq("lat4_rst_frz", l4_frz, 0);
    check_eq("lat4_rst_wr", {l4_pc_wr, l4_if2id_wr}, 2'b11);
    check_eq("lat4_rst_flushes", {l4_if2id_flush, l4_id2ex_flush, l4_ex2mem_flush}, 3'b111);
    tick();
    rst = 0;
    clear_in();
    settle();
    check_eq("lat4_after_rst_frz", l4_frz, 0);
    check_eq("lat4_after_rst_counters", {l4_stall, l4_flush}, 0);
    tick();
    check_eq("lat4_after_rst_frz2", l4_frz, 0);

    // FWD_EN=0: producers 1, 2 and 3 stages ahead
    do_reset();
    id_rs = 7; id_use_rs = 1; ex_rs = 7; ex_rt = 7;
    dep(1);
    check_eq("nf_stall_after_d1", nf_stall, 3);
    dep(2);
    check_eq("nf_stall_after_d2", nf_stall, 5);
    dep(3);
    check_eq("nf_stall_after_d3", nf_stall, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
